// File: rtl/adc_power_sequencer.sv
// ADC power sequencer: powers up, initialises, calibrates, samples,
// sleeps and shuts down a bank of ADCs under a single timed FSM.
//
// Ports:
//   Clock, Reset               rising-edge clock, async active-high reset
//   OutToADCEnable             master power permission (low forces shutdown)
//   adcPwrOn/Off, adcSleep,
//   adcWake, adcRunCal         single-cycle commands
//   FaultClear                 leaves FAULT
//   ChannelMask                channels taking part in calibration
//   ADCClockLocked             sample clock locked
//   InCalRunning               per-channel calibration busy
//   RegWriteDone               serial writer finished (pulse)
//   RegWriteReq / RegWriteOp   serial write request and opcode
//   ADCPower, AnalogPower      supply enables
//   CalRequest                 per-channel calibration request
//   Sampling, Fault, FaultCode status
//   State                      current state encoding
module adc_power_sequencer #(
  parameter int NUM_ADC          = 2,
  parameter int TIMER_W          = 24,
  parameter int ADC_WARM_CYC     = 256,
  parameter int INIT_SETTLE_CYC  = 128,
  parameter int WAKE_CYC         = 128,
  parameter int SHUTDOWN_CYC     = 256,
  parameter int LOCK_TIMEOUT_CYC = 2**23,
  parameter int CAL_TIMEOUT_CYC  = 2**20,
  parameter int CAL_RETRIES      = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               OutToADCEnable,
  input  logic               adcPwrOn,
  input  logic               adcPwrOff,
  input  logic               adcSleep,
  input  logic               adcWake,
  input  logic               adcRunCal,
  input  logic               FaultClear,
  input  logic [NUM_ADC-1:0] ChannelMask,
  input  logic               ADCClockLocked,
  input  logic [NUM_ADC-1:0] InCalRunning,
  input  logic               RegWriteDone,
  output logic               RegWriteReq,
  output logic [1:0]         RegWriteOp,
  output logic               ADCPower,
  output logic               AnalogPower,
  output logic [NUM_ADC-1:0] CalRequest,
  output logic               Sampling,
  output logic               Fault,
  output logic [1:0]         FaultCode,
  output logic [3:0]         State
);

  typedef enum logic [3:0] {
    S_OFF         = 4'd0,
    S_ADC_WARM    = 4'd1,
    S_ANALOG_WARM = 4'd2,
    S_INIT_WRITE  = 4'd3,
    S_INIT_SETTLE = 4'd4,
    S_CAL_REQ     = 4'd5,
    S_CAL         = 4'd6,
    S_EN_DES      = 4'd7,
    S_SAMPLING    = 4'd8,
    S_DIS_SLEEP   = 4'd9,
    S_SLEEP       = 4'd10,
    S_WAKE        = 4'd11,
    S_DIS_CAL     = 4'd12,
    S_SHUTDOWN    = 4'd13,
    S_FAULT       = 4'd14
  } state_t;

  localparam int RW = $clog2(CAL_RETRIES + 2);

  localparam logic [TIMER_W-1:0] T_WARM  = TIMER_W'(ADC_WARM_CYC - 1);
  localparam logic [TIMER_W-1:0] T_SETTL = TIMER_W'(INIT_SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] T_WAKE  = TIMER_W'(WAKE_CYC - 1);
  localparam logic [TIMER_W-1:0] T_SHUT  = TIMER_W'(SHUTDOWN_CYC - 1);
  localparam logic [TIMER_W-1:0] T_LOCK  = TIMER_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] T_CAL   = TIMER_W'(CAL_TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [NUM_ADC-1:0]   mask_q, mask_d;
  logic [1:0]           code_q, code_d;

  logic restart;
  logic cal_fail;
  logic wr_fail;
  logic cal_up;
  logic cal_dn;
  logic abort;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_OFF;
      timer_q <= '0;
      retry_q <= '0;
      mask_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    mask_d   = mask_q;
    code_d   = code_q;
    restart  = 1'b0;
    cal_fail = 1'b0;
    wr_fail  = 1'b0;
    // unmasked channels count as both busy and idle
    cal_up   = &(InCalRunning | ~mask_q);
    cal_dn   = ~|(InCalRunning & mask_q);
    abort    = !OutToADCEnable &&
               !(state_q inside {S_OFF, S_SHUTDOWN, S_FAULT});

    if (abort) begin
      state_d = S_SHUTDOWN;
    end else begin
      unique case (state_q)
        S_OFF:
          if (adcPwrOn && OutToADCEnable) state_d = S_ADC_WARM;
        S_ADC_WARM:
          if (timer_q == T_WARM) state_d = S_ANALOG_WARM;
        S_ANALOG_WARM:
          if (ADCClockLocked) state_d = S_INIT_WRITE;
          else if (timer_q == T_LOCK) begin
            state_d = S_FAULT;
            code_d  = 2'd1;
          end
        S_INIT_WRITE:
          if (RegWriteDone) state_d = S_INIT_SETTLE;
          else wr_fail = (timer_q == T_CAL);
        S_INIT_SETTLE:
          if (timer_q == T_SETTL) state_d = S_CAL_REQ;
        S_CAL_REQ:
          if (cal_up) state_d = S_CAL;
          else cal_fail = (timer_q == T_CAL);
        S_CAL:
          if (cal_dn) state_d = S_EN_DES;
          else cal_fail = (timer_q == T_CAL);
        S_EN_DES:
          if (RegWriteDone) state_d = S_SAMPLING;
          else wr_fail = (timer_q == T_CAL);
        S_SAMPLING:
          if (adcPwrOff) state_d = S_SHUTDOWN;
          else if (adcSleep) state_d = S_DIS_SLEEP;
          else if (adcRunCal) state_d = S_DIS_CAL;
        S_DIS_SLEEP:
          if (RegWriteDone) state_d = S_SLEEP;
          else wr_fail = (timer_q == T_CAL);
        S_SLEEP:
          if (adcPwrOff) state_d = S_SHUTDOWN;
          else if (adcWake) state_d = S_WAKE;
        S_WAKE:
          if (timer_q == T_WAKE) state_d = S_EN_DES;
        S_DIS_CAL:
          if (RegWriteDone) state_d = S_CAL_REQ;
          else wr_fail = (timer_q == T_CAL);
        S_SHUTDOWN:
          if (timer_q == T_SHUT) state_d = S_OFF;
        S_FAULT:
          if (FaultClear) begin
            state_d = S_OFF;
            code_d  = 2'd0;
          end
        default:
          state_d = S_OFF;
      endcase
    end

    if (wr_fail) begin
      state_d = S_FAULT;
      code_d  = 2'd3;
    end

    if (cal_fail) begin
      retry_d = retry_q + RW'(1);
      if (retry_q >= RW'(CAL_RETRIES)) begin
        state_d = S_FAULT;
        code_d  = 2'd2;
      end else begin
        // re-entry of CAL_REQ: fresh timer and fresh mask
        state_d = S_CAL_REQ;
        restart = 1'b1;
      end
    end

    if (state_d == S_CAL_REQ && (state_q != S_CAL_REQ || restart))
      mask_d = ChannelMask;

    if (state_d == S_SAMPLING && state_q != S_SAMPLING)
      retry_d = '0;

    if (state_d != state_q || restart)
      timer_d = '0;
    else if (&timer_q)
      timer_d = timer_q;
    else
      timer_d = timer_q + TIMER_W'(1);

    ADCPower    = !(state_q inside {S_OFF, S_FAULT});
    AnalogPower = OutToADCEnable &&
                  !(state_q inside {S_OFF, S_ADC_WARM,
                                    S_SHUTDOWN, S_FAULT});
    RegWriteReq = state_q inside {S_INIT_WRITE, S_EN_DES,
                                  S_DIS_SLEEP, S_DIS_CAL};
    RegWriteOp  = 2'd0;
    if (state_q == S_EN_DES) RegWriteOp = 2'd1;
    if (state_q inside {S_DIS_SLEEP, S_DIS_CAL}) RegWriteOp = 2'd2;
    CalRequest  = (state_q == S_CAL_REQ) ? mask_q : '0;
    Sampling    = (state_q == S_SAMPLING);
    Fault       = (state_q == S_FAULT);
    FaultCode   = code_q;
    State       = state_q;
  end

endmodule

// File: tb/tb_adc_power_sequencer.sv
// Bench for adc_power_sequencer: directed scenarios, a cycle-level
// reference model compared every clock, and literal duration checks.
module tb_adc_power_sequencer;

  localparam int LOCK_TO = 600;
  localparam int CAL_TO  = 200;
  localparam int RETRIES = 2;

  localparam int OFF = 0, WARM = 1, AWARM = 2, IW = 3, IS = 4;
  localparam int CREQ = 5, CAL = 6, EN = 7, SAMP = 8, DS = 9;
  localparam int SLP = 10, WAKE = 11, DC = 12, SD = 13, FLT = 14;

  localparam logic [5:0] C_ON  = 6'b000001;
  localparam logic [5:0] C_OFF = 6'b000010;
  localparam logic [5:0] C_SLP = 6'b000100;
  localparam logic [5:0] C_WAK = 6'b001000;
  localparam logic [5:0] C_CAL = 6'b010000;
  localparam logic [5:0] C_CLR = 6'b100000;

  logic       Clock = 0;
  logic       Reset = 1;
  logic       en = 0;
  logic [5:0] cmd = '0;
  logic [1:0] ChannelMask = 2'b11;
  logic       lock = 0;
  logic [1:0] InCalRunning = '0;
  logic       done_auto = 0;
  logic       done_stray = 0;
  logic       done_w;
  logic [1:0] cal_ok = 2'b11;

  logic       RegWriteReq;
  logic [1:0] RegWriteOp;
  logic       ADCPower, AnalogPower, Sampling, Fault;
  logic [1:0] CalRequest, FaultCode;
  logic [3:0] State;

  int vectors = 0;
  int miscompares = 0;
  int last_dur [16];
  int prev_st = 0;
  int run_len = 0;

  assign done_w = done_auto | done_stray;

  adc_power_sequencer #(
    .NUM_ADC(2),
    .LOCK_TIMEOUT_CYC(LOCK_TO),
    .CAL_TIMEOUT_CYC(CAL_TO),
    .CAL_RETRIES(RETRIES)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .OutToADCEnable(en),
    .adcPwrOn(cmd[0]),
    .adcPwrOff(cmd[1]),
    .adcSleep(cmd[2]),
    .adcWake(cmd[3]),
    .adcRunCal(cmd[4]),
    .FaultClear(cmd[5]),
    .ChannelMask(ChannelMask),
    .ADCClockLocked(lock),
    .InCalRunning(InCalRunning),
    .RegWriteDone(done_w),
    .RegWriteReq(RegWriteReq),
    .RegWriteOp(RegWriteOp),
    .ADCPower(ADCPower),
    .AnalogPower(AnalogPower),
    .CalRequest(CalRequest),
    .Sampling(Sampling),
    .Fault(Fault),
    .FaultCode(FaultCode),
    .State(State)
  );

  always #5 Clock = ~Clock;

  // reference model: state, cycles spent in it, tries, mask, code
  typedef struct {
    int         st;
    int         age;
    int         tries;
    logic [1:0] mask;
    logic [1:0] code;
  } model_t;

  model_t m = '{OFF, 0, 0, 2'b00, 2'b00};

  function automatic model_t step(model_t c);
    model_t n = c;
    int nx = c.st;
    bit re = 0;
    bit hi = ((InCalRunning | ~c.mask) == 2'b11);
    bit lo = ((InCalRunning & c.mask) == 2'b00);
    bit tmo_cal = (c.age + 1 == CAL_TO);
    if (!en && !(c.st inside {OFF, SD, FLT})) nx = SD;
    else begin
      case (c.st)
        OFF:   if (cmd[0] && en) nx = WARM;
        WARM:  if (c.age + 1 == 256) nx = AWARM;
        AWARM: if (lock) nx = IW;
               else if (c.age + 1 == LOCK_TO) begin
                 nx = FLT; n.code = 1;
               end
        IS:    if (c.age + 1 == 128) nx = CREQ;
        WAKE:  if (c.age + 1 == 128) nx = EN;
        SD:    if (c.age + 1 == 256) nx = OFF;
        SAMP:  if (cmd[1]) nx = SD;
               else if (cmd[2]) nx = DS;
               else if (cmd[4]) nx = DC;
        SLP:   if (cmd[1]) nx = SD;
               else if (cmd[3]) nx = WAKE;
        FLT:   if (cmd[5]) begin nx = OFF; n.code = 0; end
        IW, EN, DS, DC:
          if (done_w)
            nx = (c.st == IW) ? IS : (c.st == EN) ? SAMP :
                 (c.st == DS) ? SLP : CREQ;
          else if (tmo_cal) begin nx = FLT; n.code = 3; end
        CREQ, CAL:
          if (c.st == CREQ && hi) nx = CAL;
          else if (c.st == CAL && lo) nx = EN;
          else if (tmo_cal) begin
            n.tries = c.tries + 1;
            if (n.tries > RETRIES) begin nx = FLT; n.code = 2; end
            else begin nx = CREQ; re = 1; end
          end
        default: nx = OFF;
      endcase
    end
    n.age = (nx != c.st || re) ? 0 : c.age + 1;
    if (nx == CREQ && (c.st != CREQ || re)) n.mask = ChannelMask;
    if (nx == SAMP && c.st != SAMP) n.tries = 0;
    n.st = nx;
    return n;
  endfunction

  initial forever begin
    @(posedge Clock or posedge Reset);
    if (Reset) m = '{OFF, 0, 0, 2'b00, 2'b00};
    else m = step(m);
  end

  // per-cycle comparison against the model
  initial forever begin
    logic e_adc, e_ana, e_req;
    logic [1:0] e_op, e_cal;
    bit bad;
    @(negedge Clock);
    if (!Reset) begin
      e_adc = !(m.st inside {OFF, FLT});
      e_ana = en && !(m.st inside {OFF, WARM, SD, FLT});
      e_req = m.st inside {IW, EN, DS, DC};
      e_op  = (m.st == IW) ? 2'd0 : (m.st == EN) ? 2'd1 : 2'd2;
      e_cal = (m.st == CREQ) ? m.mask : 2'b00;
      bad = (int'(State) != m.st) || ADCPower !== e_adc ||
            AnalogPower !== e_ana || RegWriteReq !== e_req ||
            (e_req && RegWriteOp !== e_op) || CalRequest !== e_cal ||
            Sampling !== (m.st == SAMP) || Fault !== (m.st == FLT) ||
            FaultCode !== m.code;
      vectors++;
      if (bad) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL cycle t=%0t: got st=%0d pw=%b%b req=%b op=%0d cal=%b smp=%b flt=%b code=%0d, want st=%0d pw=%b%b req=%b op=%0d cal=%b smp=%b flt=%b code=%0d",
                   $time, State, ADCPower, AnalogPower, RegWriteReq,
                   RegWriteOp, CalRequest, Sampling, Fault, FaultCode,
                   m.st, e_adc, e_ana, e_req, e_op, e_cal,
                   m.st == SAMP, m.st == FLT, m.code);
      end
    end
  end

  // run length of each state visit, recorded on exit
  initial forever begin
    @(negedge Clock);
    if (int'(State) == prev_st) run_len++;
    else begin
      last_dur[prev_st] = run_len;
      prev_st = int'(State);
      run_len = 1;
    end
  end

  // serial writer: finishes each request after 5 observed cycles
  initial begin
    int wc = 0;
    forever begin
      @(posedge Clock);
      #2;
      done_auto = 0;
      if (RegWriteReq && !Reset) begin
        wc++;
        if (wc == 5) begin done_auto = 1; wc = 0; end
      end else wc = 0;
    end
  end

  // calibration engine: starts 2 cycles after request, busy 50 cycles
  initial begin
    int cc [2] = '{0, 0};
    forever begin
      @(posedge Clock);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (Reset) cc[i] = 0;
        else if (cc[i] == 0) begin
          if (CalRequest[i] && cal_ok[i]) cc[i] = 1;
        end else cc[i] = (cc[i] == 53) ? 0 : cc[i] + 1;
        InCalRunning[i] = (cc[i] >= 3 && cc[i] <= 52);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int maxc);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (int'(State) != s && n < maxc);
    #1;
    chk($sformatf("reach_state_%0d", s), int'(State), s);
  endtask

  task automatic pulse(input logic [5:0] c);
    @(posedge Clock);
    #2;
    cmd = c;
    @(posedge Clock);
    #2;
    cmd = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge Clock);
    #1;
    chk("rst_state", int'(State), 0);
    chk("rst_outs", int'({ADCPower, AnalogPower, RegWriteReq, Sampling,
                          Fault, CalRequest, FaultCode}), 0);
    @(posedge Clock);
    #2;
    Reset = 0;
    en = 1;

    // power-up to sampling, lock 10 cycles into ANALOG_WARM
    pulse(C_ON);
    wait_state(AWARM, 300);
    chk("adc_warm_len", last_dur[WARM], 256);
    repeat (10) @(posedge Clock);
    #2;
    lock = 1;
    wait_state(SAMP, 600);

    // dropped wake and stray write-done while sampling
    pulse(C_WAK);
    @(posedge Clock);
    #2;
    done_stray = 1;
    @(posedge Clock);
    #2;
    done_stray = 0;
    @(negedge Clock);
    #1;
    chk("stray_ignored", int'(State), SAMP);

    // sleep / wake
    pulse(C_SLP);
    wait_state(SLP, 50);
    pulse(C_WAK);
    wait_state(SAMP, 300);
    chk("wake_len", last_dur[WAKE], 128);

    // recalibration from sampling
    pulse(C_CAL);
    wait_state(CREQ, 50);
    wait_state(SAMP, 200);

    // sleep and power-off together: power-off wins
    pulse(C_SLP | C_OFF);
    @(negedge Clock);
    #1;
    chk("off_wins", int'(State), SD);
    wait_state(OFF, 300);
    chk("shutdown_len", last_dur[SD], 256);

    // permission dropped during EN_DES
    pulse(C_ON);
    wait_state(EN, 800);
    en = 0;
    @(negedge Clock);
    #1;
    chk("en_drop_state", int'(State), SD);
    chk("en_drop_req", int'(RegWriteReq), 0);
    wait_state(OFF, 300);
    en = 1;

    // lock never arrives
    lock = 0;
    pulse(C_ON);
    wait_state(FLT, 1000);
    chk("lock_code", int'(FaultCode), 1);
    chk("lock_wait_len", last_dur[AWARM], LOCK_TO);
    pulse(C_CLR);
    @(negedge Clock);
    #1;
    chk("clear_state", int'(State), OFF);
    chk("clear_code", int'(FaultCode), 0);

    // channel 1 never calibrates: three attempts then fault
    lock = 1;
    cal_ok = 2'b01;
    ChannelMask = 2'b11;
    pulse(C_ON);
    wait_state(FLT, 1200);
    chk("cal_code", int'(FaultCode), 2);
    chk("cal_attempts_len", last_dur[CREQ], 3 * CAL_TO);
    pulse(C_CLR);

    // masked-off channel 1 lets calibration complete
    @(posedge Clock);
    #2;
    Reset = 1;
    @(posedge Clock);
    #2;
    Reset = 0;
    ChannelMask = 2'b01;
    pulse(C_ON);
    wait_state(SAMP, 800);

    // empty mask passes CAL_REQ and CAL in one cycle each
    ChannelMask = 2'b00;
    pulse(C_CAL);
    wait_state(SAMP, 100);
    chk("empty_creq_len", last_dur[CREQ], 1);
    chk("empty_cal_len", last_dur[CAL], 1);

    // asynchronous reset mid-calibration
    ChannelMask = 2'b11;
    cal_ok = 2'b11;
    pulse(C_CAL);
    wait_state(CAL, 100);
    #2;
    Reset = 1;
    #1;
    chk("async_rst_state", int'(State), 0);
    chk("async_rst_outs", int'({ADCPower, AnalogPower, RegWriteReq,
                                Sampling, Fault, CalRequest}), 0);
    @(posedge Clock);
    #2;
    Reset = 0;
    repeat (5) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
